// File: rtl/riscv_pkg.sv
// RV32 load/store funct3 encodings, LSU state encoding and an alignment helper.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // size is funct3[1:0]: 01 halfword, 10 word; byte accesses are always aligned
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == 2'b01) && a[0]) || ((size == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the LSU (master) and the memory system (slave).
interface lsu_if;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    logic        dgnt;
    logic        drvalid;
    logic [31:0] drdata;

    modport master (
        output dreq, dwe, daddr, dbe, dwdata,
        input  dgnt, drvalid, drdata
    );

    modport slave (
        input  dreq, dwe, daddr, dbe, dwdata,
        output dgnt, drvalid, drdata
    );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        case (addr_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            default: byte_s = word_i[31:24];
        endcase
        half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   result_o = 32'(byte_s);
            F3_LH:   result_o = 32'(half_s);
            F3_LW:   result_o = word_i;
            F3_LBU:  result_o = {24'd0, byte_s};
            F3_LHU:  result_o = {16'd0, half_s};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus access at a time, stalling the pipeline until it finishes.
// Define LSU_TIMEOUT_EN to abort an access after BUS_TIMEOUT cycles with BusErrM.
module lsu
    import riscv_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    lsu_if.master       dbus
);

    if (BUS_TIMEOUT == 0) begin : g_bad_timeout
        $error("lsu: BUS_TIMEOUT must be non-zero");
    end

    lsu_state_e  state_q, state_d;
    logic [31:0] daddr_q, dwdata_q, rdata_q;
    logic [3:0]  dbe_q;
    logic        dwe_q;
    logic [2:0]  f3_q;
    logic [1:0]  alo_q;

    logic        mem_op, misaligned, start, capture, busy, timeout, tmo_err;
    logic        stall, mis;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ext_data;

    assign mem_op     = MemReadM | MemWriteM;
    assign misaligned = is_misaligned(funct3M[1:0], ALUResultM[1:0]);
    assign busy       = (state_q == LSU_REQ) || (state_q == LSU_WAIT);
    assign capture    = (state_q == LSU_WAIT) && dbus.drvalid;

    // Loads read the whole word; stores replicate the data across every lane
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = '0;
        if (MemWriteM) begin
            case (funct3M)
                F3_SB: begin
                    be_d    = 4'b0001 << ALUResultM[1:0];
                    wdata_d = {4{WriteDataM[7:0]}};
                end
                F3_SH: begin
                    be_d    = 4'b0011 << ALUResultM[1:0];
                    wdata_d = {2{WriteDataM[15:0]}};
                end
                F3_SW: begin
                    be_d    = 4'b1111;
                    wdata_d = WriteDataM;
                end
                default: begin
                    be_d    = 4'b0000;
                    wdata_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        mis     = 1'b0;
        start   = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        mis = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        start   = 1'b1;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                stall = 1'b1;
                if (timeout)        state_d = LSU_DONE;
                else if (dbus.dgnt) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                stall = 1'b1;
                if (dbus.drvalid || timeout) state_d = LSU_DONE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LSU_IDLE;
            daddr_q  <= '0;
            dbe_q    <= '0;
            dwe_q    <= 1'b0;
            dwdata_q <= '0;
            f3_q     <= '0;
            alo_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                daddr_q  <= {ALUResultM[31:2], 2'b00};
                dbe_q    <= be_d;
                dwe_q    <= MemWriteM;
                dwdata_q <= wdata_d;
                f3_q     <= funct3M;
                alo_q    <= ALUResultM[1:0];
            end
            if (capture) rdata_q <= dbus.drdata;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tmo_err_q;

    assign timeout = busy && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    // A read that completes in the expiry cycle still counts as a success
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (start)     cnt_q <= '0;
            else if (busy) cnt_q <= cnt_q + 1'b1;
            if (start)                    tmo_err_q <= 1'b0;
            else if (timeout && !capture) tmo_err_q <= 1'b1;
        end
    end

    assign tmo_err = tmo_err_q;
    assign BusErrM = (state_q == LSU_DONE) && tmo_err_q;
`else
    assign timeout = 1'b0;
    assign tmo_err = 1'b0;
    assign BusErrM = 1'b0;
`endif

    load_extend u_load_extend (
        .word_i   (rdata_q),
        .addr_i   (alo_q),
        .funct3_i (f3_q),
        .result_o (ext_data)
    );

    assign ReadDataM = (state_q == LSU_DONE && !dwe_q && !tmo_err) ? ext_data : '0;
    assign StallM    = reset & stall;
    assign MisalignM = reset & mis;

    assign dbus.dreq   = (state_q == LSU_REQ);
    assign dbus.dwe    = dwe_q;
    assign dbus.daddr  = daddr_q;
    assign dbus.dbe    = dbe_q;
    assign dbus.dwdata = dwdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: drives a cycle-scripted bus responder and checks hand-computed results.
module tb_lsu;
    import riscv_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  funct3M = 3'b000;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;

    lsu_if dbus();

    lsu #(.BUS_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .dbus       (dbus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    int          obs_stall, obs_mis, obs_dreq;
    logic        obs_done, obs_stable, obs_seen, obs_berr, obs_we;
    logic [31:0] obs_rdm, obs_addr, obs_wd;
    logic [3:0]  obs_be;

    // Cycle 0 is the IDLE cycle presenting the op; dgnt arrives in cycle 1+gd,
    // drvalid in cycle 2+gd+rvd. Ends after the first cycle with StallM low.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rvd, input logic [31:0] rdat,
                          input logic stray, input int maxc);
        obs_stall = 0; obs_mis = 0; obs_dreq = 0;
        obs_done = 1'b0; obs_stable = 1'b1; obs_seen = 1'b0; obs_berr = 1'b0;
        obs_rdm = '0; obs_addr = '0; obs_wd = '0; obs_be = '0; obs_we = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            @(posedge clk); #1;
            MemReadM     = rd;
            MemWriteM    = wr;
            funct3M      = f3;
            ALUResultM   = addr;
            WriteDataM   = wd;
            dbus.dgnt    = (c == 1 + gd);
            dbus.drvalid = (c == 2 + gd + rvd) || (stray && c == 1);
            dbus.drdata  = (stray && c == 1) ? 32'hDEAD_BEEF : rdat;
            @(negedge clk);
            if (MisalignM) obs_mis++;
            if (BusErrM) obs_berr = 1'b1;
            if (dbus.dreq) begin
                obs_dreq++;
                if (!obs_seen) begin
                    obs_seen = 1'b1;
                    obs_addr = dbus.daddr;
                    obs_be   = dbus.dbe;
                    obs_wd   = dbus.dwdata;
                    obs_we   = dbus.dwe;
                end else if (dbus.daddr !== obs_addr || dbus.dbe !== obs_be ||
                             dbus.dwdata !== obs_wd || dbus.dwe !== obs_we) begin
                    obs_stable = 1'b0;
                end
            end
            if (StallM) obs_stall++;
            else begin
                obs_done = 1'b1;
                obs_rdm  = ReadDataM;
                break;
            end
        end
        @(posedge clk); #1;
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        dbus.dgnt    = 1'b0;
        dbus.drvalid = 1'b0;
    endtask

    initial begin
        dbus.dgnt    = 1'b0;
        dbus.drvalid = 1'b0;
        dbus.drdata  = '0;

        // Reset state, with a misaligned op presented during reset
        MemReadM   = 1'b1;
        funct3M    = F3_LW;
        ALUResultM = 32'h0000_0101;
        #12;
        chk("rst_dreq",   32'(dbus.dreq), 0);
        chk("rst_dwe",    32'(dbus.dwe), 0);
        chk("rst_dbe",    32'(dbus.dbe), 0);
        chk("rst_daddr",  dbus.daddr, 0);
        chk("rst_dwdata", dbus.dwdata, 0);
        chk("rst_stall",  32'(StallM), 0);
        chk("rst_mis",    32'(MisalignM), 0);
        chk("rst_berr",   32'(BusErrM), 0);
        chk("rst_rdata",  ReadDataM, 0);
        MemReadM   = 1'b0;
        ALUResultM = '0;
        @(posedge clk); #1;
        reset = 1'b1;

        // LB at 0x103, zero-latency bus
        run_op(1'b1, 1'b0, F3_LB, 32'h0000_0103, '0, 0, 0, 32'h80FF_0000, 1'b0, 20);
        chk("lb_done",  32'(obs_done), 1);
        chk("lb_stall", obs_stall, 3);
        chk("lb_rdata", obs_rdm, 32'hFFFF_FF80);
        chk("lb_daddr", obs_addr, 32'h0000_0100);
        chk("lb_dwe",   32'(obs_we), 0);
        chk("lb_dreq",  obs_dreq, 1);

        // SH at 0x202
        run_op(1'b0, 1'b1, F3_SH, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 32'h1111_1111, 1'b0, 20);
        chk("sh_daddr",  obs_addr, 32'h0000_0200);
        chk("sh_dbe",    32'(obs_be), 32'hC);
        chk("sh_dwdata", obs_wd, 32'hABCD_ABCD);
        chk("sh_dwe",    32'(obs_we), 1);
        chk("sh_stall",  obs_stall, 3);
        chk("sh_rdata",  obs_rdm, 0);

        // Misaligned LW at 0x101
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0101, '0, 0, 0, 32'hFFFF_FFFF, 1'b0, 20);
        chk("mis_flag",  obs_mis, 1);
        chk("mis_stall", obs_stall, 0);
        chk("mis_dreq",  obs_dreq, 0);
        chk("mis_rdata", obs_rdm, 0);
        @(negedge clk);
        chk("mis_after_dreq", 32'(dbus.dreq), 0);
        chk("mis_after_flag", 32'(MisalignM), 0);

        // Misaligned LH at 0x103
        run_op(1'b1, 1'b0, F3_LH, 32'h0000_0103, '0, 0, 0, '0, 1'b0, 20);
        chk("lh_mis_flag", obs_mis, 1);
        chk("lh_mis_dreq", obs_dreq, 0);

        // LW with dgnt delayed by 4 cycles
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0100, '0, 4, 0, 32'h1234_5678, 1'b0, 30);
        chk("gnt4_stall",  obs_stall, 7);
        chk("gnt4_dreq",   obs_dreq, 5);
        chk("gnt4_stable", 32'(obs_stable), 1);
        chk("gnt4_daddr",  obs_addr, 32'h0000_0100);
        chk("gnt4_rdata",  obs_rdm, 32'h1234_5678);

        // Load extension variants
        run_op(1'b1, 1'b0, F3_LBU, 32'h0000_0101, '0, 0, 0, 32'h0000_9A00, 1'b0, 20);
        chk("lbu_rdata", obs_rdm, 32'h0000_009A);
        run_op(1'b1, 1'b0, F3_LH, 32'h0000_0102, '0, 0, 0, 32'h8001_7FFF, 1'b0, 20);
        chk("lh_rdata", obs_rdm, 32'hFFFF_8001);
        run_op(1'b1, 1'b0, F3_LHU, 32'h0000_0102, '0, 0, 0, 32'h8001_7FFF, 1'b0, 20);
        chk("lhu_rdata", obs_rdm, 32'h0000_8001);
        run_op(1'b1, 1'b0, F3_LH, 32'h0000_0100, '0, 0, 1, 32'h1234_F00F, 1'b0, 20);
        chk("lh_lo_rdata", obs_rdm, 32'hFFFF_F00F);
        chk("lh_lo_stall", obs_stall, 4);
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_0100, '0, 0, 0, 32'hFFFF_FFFF, 1'b0, 20);
        chk("f3_011_rdata", obs_rdm, 0);

        // Store lanes
        run_op(1'b0, 1'b1, F3_SB, 32'h0000_0101, 32'h1234_565A, 0, 0, '0, 1'b0, 20);
        chk("sb_dbe",    32'(obs_be), 32'h2);
        chk("sb_dwdata", obs_wd, 32'h5A5A_5A5A);
        run_op(1'b0, 1'b1, F3_SW, 32'h0000_010C, 32'hCAFE_F00D, 0, 0, '0, 1'b0, 20);
        chk("sw_dbe",    32'(obs_be), 32'hF);
        chk("sw_daddr",  obs_addr, 32'h0000_010C);
        chk("sw_dwdata", obs_wd, 32'hCAFE_F00D);

        // Read and write together: write wins
        run_op(1'b1, 1'b1, F3_SW, 32'h0000_0204, 32'h1122_3344, 0, 0, 32'h5555_5555, 1'b0, 20);
        chk("rw_dwe",   32'(obs_we), 1);
        chk("rw_rdata", obs_rdm, 0);

        // Stray drvalid while still in REQ is ignored
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0500, '0, 2, 0, 32'h0BAD_C0DE, 1'b1, 20);
        chk("stray_stall", obs_stall, 5);
        chk("stray_rdata", obs_rdm, 32'h0BAD_C0DE);

        // Stray dgnt/drvalid while IDLE
        @(posedge clk); #1;
        dbus.dgnt    = 1'b1;
        dbus.drvalid = 1'b1;
        dbus.drdata  = 32'h7777_7777;
        @(negedge clk);
        chk("idle_stray_stall", 32'(StallM), 0);
        @(posedge clk); #1;
        dbus.dgnt    = 1'b0;
        dbus.drvalid = 1'b0;
        @(negedge clk);
        chk("idle_stray_dreq",  32'(dbus.dreq), 0);
        chk("idle_stray_rdata", ReadDataM, 0);

`ifdef LSU_TIMEOUT_EN
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0300, '0, 0, 1000, 32'h9999_9999, 1'b0, 64);
        chk("tmo_done",  32'(obs_done), 1);
        chk("tmo_stall", obs_stall, TMO + 1);
        chk("tmo_berr",  32'(obs_berr), 1);
        chk("tmo_rdata", obs_rdm, 0);
        @(negedge clk);
        chk("tmo_idle_stall", 32'(StallM), 0);
        chk("tmo_idle_berr",  32'(BusErrM), 0);
`else
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0300, '0, 0, 1000, 32'h9999_9999, 1'b0, 40);
        chk("wait_forever", 32'(obs_done), 0);
        chk("wait_stall",   obs_stall, 40);
        chk("wait_berr",    32'(obs_berr), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
`endif

        // Reset while in REQ
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0400, '0, 1000, 0, '0, 1'b0, 2);
        chk("req_hold_dreq", 32'(dbus.dreq), 1);
        reset = 1'b0;
        #1;
        chk("req_rst_dreq",  32'(dbus.dreq), 0);
        chk("req_rst_daddr", dbus.daddr, 0);
        chk("req_rst_stall", 32'(StallM), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset while in WAIT, then a late drvalid
        run_op(1'b1, 1'b0, F3_LW, 32'h0000_0404, '0, 0, 1000, '0, 1'b0, 3);
        chk("wait_hold_stall", 32'(StallM), 1);
        reset = 1'b0;
        #1;
        chk("wait_rst_stall", 32'(StallM), 0);
        chk("wait_rst_dreq",  32'(dbus.dreq), 0);
        @(posedge clk); #1;
        reset        = 1'b1;
        dbus.drvalid = 1'b1;
        dbus.drdata  = 32'hABAB_ABAB;
        @(negedge clk);
        chk("late_rv_stall", 32'(StallM), 0);
        chk("late_rv_rdata", ReadDataM, 0);
        @(posedge clk); #1;
        dbus.drvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_dreq",  32'(dbus.dreq), 0);
        chk("late_rv_rdata2", ReadDataM, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter BUS_TIMEOUT, default 16: cycles allowed in REQ+WAIT before abort (used only with LSU_TIMEOUT_EN).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 MemReadM  input  1  memory-stage load.
REQ-005 MemWriteM  input  1  memory-stage store.
REQ-006 funct3M  input  3  access size/sign.
REQ-007 ALUResultM  input  32  byte address.
REQ-008 WriteDataM  input  32  store data, LSB-aligned.
REQ-009 ReadDataM  output  32  extended load data to writeback register.
REQ-010 StallM  output  1  holds the whole pipeline while high.
REQ-011 MisalignM  output  1  misaligned access flag.
REQ-012 BusErrM  output  1  bus timeout flag.
REQ-013 dreq  output  1  bus request.
REQ-014 dwe  output  1  bus write enable.
REQ-015 daddr  output  32  word address, bits[1:0]=0.
REQ-016 dbe  output  4  byte enables.
REQ-017 dwdata  output  32  lane-replicated store data.
REQ-018 dgnt  input  1  request accepted.
REQ-019 drvalid  input  1  read data valid / write acknowledge.
REQ-020 drdata  input  32  read data word.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE; write wins if MemReadM and MemWriteM are both high.
REQ-022 IDLE: aligned memory op -> StallM=1 combinationally, next REQ; no op -> stay in IDLE, StallM=0.
REQ-023 REQ: dreq=1, StallM=1; daddr, dbe, dwe, dwdata are registered on IDLE->REQ and held stable until dgnt; dgnt -> WAIT.
REQ-024 WAIT: dreq=0, StallM=1; drvalid -> capture drdata, next DONE.
REQ-025 DONE: StallM=0, ReadDataM driven from the captured word, next IDLE; minimum stall is 3 cycles (dgnt and drvalid each arrive in their first cycle).
REQ-026 Misalignment: halfword with addr[0]=1 or word with addr[1:0]!=0 -> no bus request, MisalignM=1 and StallM=0 for that cycle, ReadDataM=0.
REQ-027 Load extension on addr[1:0]: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; other codes return 0.
REQ-028 Store lanes: SB dbe=0001<<addr[1:0] with byte replicated x4; SH dbe=0011<<addr[1:0] with half replicated x2; SW dbe=1111.
REQ-029 ReadDataM=0 whenever the state is not DONE or the access was a store.
REQ-030 drvalid or dgnt outside their expected state is ignored.

Reset
REQ-031 reset low asynchronously forces IDLE and sets dreq=0, dwe=0, dbe=0, daddr=0, dwdata=0, captured data=0, StallM=0, MisalignM=0, BusErrM=0.
REQ-032 Reset during REQ/WAIT abandons the access; a late drvalid after reset is ignored.

Configuration
REQ-033 Macro LSU_TIMEOUT_EN defined: a counter cleared on IDLE->REQ increments in REQ/WAIT; at BUS_TIMEOUT the FSM goes to DONE with BusErrM=1 for that cycle and ReadDataM=0.
REQ-034 LSU_TIMEOUT_EN undefined: no counter is built, REQ/WAIT wait indefinitely, and BusErrM is tied 0.

Structure
REQ-035 Shared package riscv_pkg SHALL hold the funct3 load/store encodings and the LSU state encoding.
REQ-036 Combinational sub-module load_extend (word, addr[1:0], funct3 -> 32-bit result) SHALL perform the REQ-027 extension.

Verification
REQ-037 LB at 0x103, drdata=0x80FF_0000, dgnt and drvalid in their first cycle -> ReadDataM=0xFFFFFF80, StallM high exactly 3 cycles.
REQ-038 SH at 0x202, WriteDataM=0x0000_ABCD -> daddr=0x200, dbe=1100, dwdata=0xABCDABCD, dwe=1.
REQ-039 LW at 0x101 -> MisalignM=1 for 1 cycle, dreq never asserted, StallM=0.
REQ-040 dgnt delayed 4 cycles -> dreq and daddr stable throughout, StallM high for 7 cycles.
REQ-041 With LSU_TIMEOUT_EN and no drvalid -> BusErrM=1 at cycle BUS_TIMEOUT, FSM returns to IDLE; reset asserted in WAIT -> dreq=0 immediately.
